// File: rtl/trace_serializer.sv
`timescale 1ns/1ps
// trace_serializer
// Snapshots one CPU trace record (pc, opcode, two operands, result, flags)
// when the producer flags it valid, ships it as six back-to-back 8N1 UART
// bytes on data_out, acknowledges the producer with a one-cycle next_out
// pulse, then holds off for HOLDOFF cycles before accepting the next record.
//
// Byte order on the wire: pc, opcode, operand A, operand B, result, flags,
// where flags = {6'b0, borrow, carry}. Each byte is start(0), 8 data bits
// LSB first, stop(1); every bit lasts CLKS_PER_BIT cycles.

module trace_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4,  // 1..255
  parameter int unsigned HOLDOFF      = 6   // 4..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       result_ready,
  input  logic [7:0] pc_out,
  input  logic [7:0] opcode,
  input  logic [7:0] operand_A_out,
  input  logic [7:0] operand_B_out,
  input  logic [7:0] result_out_cpu,
  input  logic       carry_out_cpu,
  input  logic       borrow_out_cpu,
  output logic       next_out,
  output logic       data_out,
  output logic       busy,
  output logic [7:0] record_count
);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  // Terminal counts for the bit timer and the hold-off counter
  localparam logic [7:0] TMR_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

  // Frame geometry: bit 0 is the start bit, 1..8 data, 9 the stop bit
  localparam logic [3:0] BIT_LAST_DATA = 4'd8;
  localparam logic [3:0] BIT_STOP      = 4'd9;
  localparam logic [2:0] BYTE_LAST     = 3'd5;

  // State and counters
  logic [2:0] state_q, state_d;
  logic [7:0] tmr_q, tmr_d;            // cycles into the current bit
  logic [3:0] bit_idx_q, bit_idx_d;    // bit within the current byte
  logic [2:0] byte_idx_q, byte_idx_d;  // byte within the record
  logic [7:0] hold_q, hold_d;          // cycles spent in HOLD

  // Record snapshot, entry 0 is sent first
  logic [5:0][7:0] snap_q, snap_d;

  // Registered outputs
  logic       data_out_q, data_out_d;
  logic       next_out_q, next_out_d;
  logic [7:0] count_q, count_d;

  // Helpers for the serial bit mux
  logic [7:0] cur_byte;
  logic [2:0] data_bit_sel;

  // Next-state logic: capture, bit/byte sequencing, acknowledge and hold-off
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    tmr_d      = tmr_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    hold_d     = hold_q;
    snap_d     = snap_q;

    case (state_q)
      S_IDLE: begin
        if (result_ready) begin
          snap_d[0]  = pc_out;
          snap_d[1]  = opcode;
          snap_d[2]  = operand_A_out;
          snap_d[3]  = operand_B_out;
          snap_d[4]  = result_out_cpu;
          snap_d[5]  = {6'b0, borrow_out_cpu, carry_out_cpu};
          state_d    = S_START;
          tmr_d      = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
        end
      end

      S_START, S_DATA, S_STOP: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d = '0;
          if (bit_idx_q == BIT_STOP) begin
            bit_idx_d = '0;
            if (byte_idx_q == BYTE_LAST) begin
              byte_idx_d = '0;
              state_d    = S_ACK;
            end else begin
              // Next byte starts immediately: no idle gap between bytes
              byte_idx_d = byte_idx_q + 3'd1;
              state_d    = S_START;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            state_d   = (bit_idx_q == BIT_LAST_DATA) ? S_STOP : S_DATA;
          end
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end

      S_ACK: begin
        state_d = S_HOLD;
        hold_d  = '0;
      end

      S_HOLD: begin
        // result_ready is deliberately not looked at here
        if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe and data_out never glitches
  always_comb begin
    cur_byte     = snap_q[byte_idx_d];
    data_bit_sel = 3'(bit_idx_d - 4'd1);
    data_out_d   = 1'b1;
    case (state_d)
      S_START: data_out_d = 1'b0;
      S_DATA:  data_out_d = cur_byte[data_bit_sel];
      default: data_out_d = 1'b1;
    endcase
    next_out_d = (state_d == S_ACK);
    count_d    = next_out_d ? (count_q + 8'd1) : count_q;
  end

  // State register with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      hold_q     <= '0;
      // NOTE: the snapshot is a handful of flops, so it is cleared with everything else.
      snap_q     <= '0;
      data_out_q <= 1'b1;
      next_out_q <= 1'b0;
      count_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      hold_q     <= hold_d;
      snap_q     <= snap_d;
      data_out_q <= data_out_d;
      next_out_q <= next_out_d;
      count_q    <= count_d;
    end
  end

  assign data_out     = data_out_q;
  assign next_out     = next_out_q;
  assign record_count = count_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_trace_serializer.sv
`timescale 1ns/1ps
// tb_trace_serializer
// Directed stimulus with a scoreboard: every record the bench expects the
// DUT to capture is pushed into exp_q; an independent UART decoder watching
// data_out reassembles each six-byte record and pops/compares it.

module tb_trace_serializer;

  localparam int CPB  = 4;
  localparam int HOLD = 6;
  localparam int SPACING = 60 * CPB + HOLD + 2;  // capture edge to capture edge
  localparam int ACK_AT  = 60 * CPB + 1;         // cycle of next_out after capture

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       carry;
    logic       borrow;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       result_ready = 1'b1;
  logic [7:0] pc_out = '0, opcode = '0, operand_A_out = '0;
  logic [7:0] operand_B_out = '0, result_out_cpu = '0;
  logic       carry_out_cpu = 1'b0, borrow_out_cpu = 1'b0;
  logic       next_out, data_out, busy;
  logic [7:0] record_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] cnt_exp = '0;
  logic [47:0] exp_q[$];

  trace_serializer #(.CLKS_PER_BIT(CPB), .HOLDOFF(HOLD)) dut (
    .clk            (clk),
    .rst            (rst),
    .result_ready   (result_ready),
    .pc_out         (pc_out),
    .opcode         (opcode),
    .operand_A_out  (operand_A_out),
    .operand_B_out  (operand_B_out),
    .result_out_cpu (result_out_cpu),
    .carry_out_cpu  (carry_out_cpu),
    .borrow_out_cpu (borrow_out_cpu),
    .next_out       (next_out),
    .data_out       (data_out),
    .busy           (busy),
    .record_count   (record_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] exp_of(input rec_t r);
    return {r.pc, r.op, r.a, r.b, r.res, 6'b0, r.borrow, r.carry};
  endfunction

  function automatic rec_t rec_of(input int k);
    logic [7:0] kb;
    rec_t r;
    kb       = k[7:0];
    r.pc     = kb;
    r.op     = kb * 8'd3 + 8'd1;
    r.a      = ~kb;
    r.b      = kb ^ 8'h5A;
    r.res    = kb + 8'h80;
    r.carry  = kb[0];
    r.borrow = kb[1];
    return r;
  endfunction

  task automatic apply(input rec_t r);
    pc_out         = r.pc;
    opcode         = r.op;
    operand_A_out  = r.a;
    operand_B_out  = r.b;
    result_out_cpu = r.res;
    carry_out_cpu  = r.carry;
    borrow_out_cpu = r.borrow;
  endtask

  // ---------------- monitor: UART decoder + scoreboard pop ----------------
  bit          dec_in  = 1'b0;
  int          dec_cnt = 0;
  int          dec_n   = 0;
  logic [7:0]  dec_byte;
  logic [47:0] dec_rec;
  logic [47:0] dec_exp;

  always @(negedge clk) begin
    if (rst) begin
      dec_in  = 1'b0;
      dec_cnt = 0;
      dec_n   = 0;
    end else if (!dec_in) begin
      if (data_out === 1'b0) begin
        dec_in  = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % CPB == 0) begin
        if (dec_cnt / CPB <= 8) begin
          dec_byte[dec_cnt / CPB - 1] = data_out;
        end else begin
          check("stop_bit", 64'(data_out), 64'd1);
          dec_in  = 1'b0;
          dec_rec = {dec_rec[39:0], dec_byte};
          dec_n++;
          if (dec_n == 6) begin
            dec_n = 0;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL record_extra: got %0h expected none", dec_rec);
            end else begin
              dec_exp = exp_q.pop_front();
              check("record", 64'(dec_rec), 64'(dec_exp));
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Stream n records with result_ready held high; inputs change after each ack
  task automatic stream(input int n, input int base);
    int pulses = 0;
    int c = 1;
    apply(rec_of(base));
    exp_q.push_back(exp_of(rec_of(base)));
    result_ready = 1'b1;
    tick();
    while (pulses < n && c < n * SPACING + 10) begin
      if (c % SPACING == 0) check("busy_idle_gap", 64'(busy), 64'd0);
      if (next_out) begin
        check("ack_cycle", 64'(c), 64'(ACK_AT + SPACING * pulses));
        pulses++;
        cnt_exp = cnt_exp + 8'd1;
        check("count_at_ack", 64'(record_count), 64'(cnt_exp));
        if (pulses < n) begin
          apply(rec_of(base + pulses));
          exp_q.push_back(exp_of(rec_of(base + pulses)));
        end else begin
          result_ready = 1'b0;
        end
      end
      tick();
      c++;
    end
    check("stream_pulses", 64'(pulses), 64'(n));
    repeat (6) tick();
    check("stream_end_busy", 64'(busy), 64'd0);
    check("stream_end_ack", 64'(next_out), 64'd0);
  endtask

  initial begin
    rec_t r1;
    int np;
    int pcyc;
    int c;

    // Reset held two cycles with result_ready high
    apply(rec_of(9));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_data_out", 64'(data_out), 64'd1);
      check("rst_next_out", 64'(next_out), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_count", 64'(record_count), 64'd0);
    end
    rst = 1'b0;
    result_ready = 1'b0;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Single record; inputs disturbed after capture, result changed at cycle 5
    r1 = '{pc: 8'h01, op: 8'h06, a: 8'h02, b: 8'h00, res: 8'h02, carry: 1'b1, borrow: 1'b0};
    apply(r1);
    exp_q.push_back(48'h01_06_02_00_02_01);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    pc_out = 8'hAA; opcode = 8'h55; operand_A_out = 8'h77; operand_B_out = 8'h88;
    carry_out_cpu = 1'b0; borrow_out_cpu = 1'b1;
    np = 0;
    pcyc = 0;
    for (int cc = 1; cc <= 250; cc++) begin
      if (cc == 1 || cc == 4) check("start_bit", 64'(data_out), 64'd0);
      if (cc == 1) check("busy_c1", 64'(busy), 64'd1);
      if (cc == 5) begin
        check("first_data_bit", 64'(data_out), 64'd1);
        result_out_cpu = 8'hFF;
      end
      if (next_out) begin
        np++;
        pcyc = cc;
        cnt_exp = cnt_exp + 8'd1;
        check("count_single", 64'(record_count), 64'(cnt_exp));
      end
      if (cc == 247) check("busy_last_hold", 64'(busy), 64'd1);
      if (cc == 248) begin
        check("busy_after_hold", 64'(busy), 64'd0);
        check("idle_line", 64'(data_out), 64'd1);
      end
      tick();
    end
    check("single_ack_count", 64'(np), 64'd1);
    check("single_ack_cycle", 64'(pcyc), 64'(ACK_AT));

    // Three back-to-back records with result_ready tied high
    stream(3, 40);

    // Reset in the middle of the third byte aborts the record
    apply(rec_of(100));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    np = 0;
    for (int cc = 1; cc < 100; cc++) begin
      if (next_out) np++;
      tick();
    end
    rst = 1'b1;
    result_ready = 1'b1;
    apply(rec_of(101));
    tick();
    check("abort_data_out", 64'(data_out), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_next_out", 64'(next_out), 64'd0);
    check("abort_count", 64'(record_count), 64'd0);
    check("abort_no_ack", 64'(np), 64'd0);
    rst = 1'b0;
    cnt_exp = '0;
    exp_q.push_back(exp_of(rec_of(101)));
    tick();
    result_ready = 1'b0;
    check("recapture_busy", 64'(busy), 64'd1);
    check("recapture_start", 64'(data_out), 64'd0);
    c = 102;
    while (!next_out && c < 400) begin
      tick();
      c++;
    end
    check("recapture_ack_cycle", 64'(c), 64'(101 + ACK_AT));
    cnt_exp = cnt_exp + 8'd1;
    check("recapture_count", 64'(record_count), 64'(cnt_exp));
    repeat (8) tick();

    // 256 consecutive records: counter wraps 255 -> 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt_exp = '0;
    stream(256, 7);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
